imem_loader: RTL

Boot-time program loader that sits between an external byte-stream source and the CPU's instruction memory write port. It packs incoming bytes MSB-first into 32-bit instruction words and writes them to consecutive word addresses starting at 0. It holds the CPU's `start_i` low until the final word is written, then raises `start_o` and keeps it high. This block is the hardware writer for the instruction memory that the CPU fetches from; it replaces file-based preloading in hardware builds.

---
 rtl/imem_loader.sv | 104 ++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader packing a byte stream into instruction memory words
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  input  logic              last_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0] imem_data_o,
  output logic              start_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] MAX_CNT  = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_nxt;
  logic [DATA_W-1:0] word_q, word_nxt;
  logic [1:0]        bcnt_q;
  logic              last_q;
  logic [ADDR_W:0]   count_q;
  logic              accept;

  assign accept = byte_valid_i && (state_q == S_LOAD);

  // An early last byte is shifted straight to its final position; stale low bytes fall off the top.
  always_comb begin
    word_nxt = {word_q[DATA_W-9:0], byte_i};
    if (last_i) begin
      case (bcnt_q)
        2'd0:    word_nxt = {byte_i, 24'h0};
        2'd1:    word_nxt = {word_q[7:0], byte_i, 16'h0};
        2'd2:    word_nxt = {word_q[15:0], byte_i, 8'h0};
        default: word_nxt = {word_q[23:0], byte_i};
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  state_nxt = S_LOAD;
      S_LOAD:  if (accept && (bcnt_q == 2'd3 || last_i)) state_nxt = S_WRITE;
      S_WRITE: begin
        if (last_q)                   state_nxt = S_DONE;
        else if (count_q == LAST_IDX) state_nxt = S_ERR;
        else                          state_nxt = S_LOAD;
      end
      S_DONE:  state_nxt = S_DONE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_q  <= '0;
      bcnt_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else if (accept) begin
      word_q <= word_nxt;
      bcnt_q <= bcnt_q + 2'd1;
      last_q <= last_i;
    end else if (state_q == S_WRITE) begin
      bcnt_q <= '0;
      if (count_q != MAX_CNT) count_q <= count_q + 1'b1;
    end
  end

  // The word index doubles as the write count, so the address is simply its low bits.
  assign byte_ready_o = (state_q == S_LOAD);
  assign imem_we_o    = (state_q == S_WRITE);
  assign imem_addr_o  = count_q[ADDR_W-1:0];
  assign imem_data_o  = word_q;
  assign start_o      = (state_q == S_DONE);
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign word_count_o = count_q;
  assign err_o        = (state_q == S_ERR);

endmodule
